// File: rtl/phasecomp_ctrl.sv
// Address and flow controller for the PFB phase-compensation ping-pong RAM: writes M-sample
// frames into one half and reads the other half back with a per-frame circular offset.
module phasecomp_ctrl #(
  parameter int FFT_LEN    = 64,
  parameter int DEC_FAC    = 48,
  parameter int DEPTH      = 2 * FFT_LEN,
  parameter int AW         = $clog2(DEPTH),
  // FFT_LEN is a power of two and DEC_FAC <= FFT_LEN, so gcd is DEC_FAC's lowest set bit
  parameter int NUM_STATES = FFT_LEN / (DEC_FAC & (-DEC_FAC)),
  parameter int SW         = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic [SW-1:0] state
);

  localparam int MW = $clog2(FFT_LEN);

  localparam logic [MW-1:0] CtrMax   = MW'(FFT_LEN - 1);
  localparam logic [MW-1:0] CtrOne   = MW'(1);
  localparam logic [MW:0]   DecFac   = (MW + 1)'(DEC_FAC);
  localparam logic [MW:0]   FftLen   = (MW + 1)'(FFT_LEN);
  localparam logic [SW-1:0] StateMax = SW'(NUM_STATES - 1);
  localparam logic [SW-1:0] StateOne = SW'(1);

  logic [1:0]    r_full;
  logic          r_wb;
  logic          r_rb;
  logic [MW-1:0] r_wctr;
  logic [MW-1:0] r_rctr;
  logic [MW-1:0] r_shift;
  logic [SW-1:0] r_state;
  logic          r_tvalid;
  logic          r_tlast;
  logic          r_tuser;

  logic          w_wr;
  logic          w_adv;
  logic [MW-1:0] w_roff;
  logic [MW:0]   w_shift_sum;
  logic [MW-1:0] w_shift_nxt;
  logic [SW-1:0] w_state_nxt;

  assign s_axis_tready = ~r_full[r_wb];
  assign w_wr          = s_axis_tvalid & s_axis_tready;
  assign w_adv         = r_full[r_rb] & (~r_tvalid | m_axis_tready);
  // Truncating add gives the circular offset within the half
  assign w_roff        = r_rctr + r_shift;

  assign ram_we        = w_wr;
  assign ram_waddr     = {r_wb, r_wctr};
  assign ram_re        = w_adv;
  assign ram_raddr     = {r_rb, w_roff};

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign state         = r_state;

  always_comb begin
    w_shift_sum = {1'b0, r_shift} + DecFac;
    w_shift_nxt = w_shift_sum[MW-1:0];
    if (w_shift_sum >= FftLen) begin
      w_shift_nxt = MW'(w_shift_sum - FftLen);
    end
    w_state_nxt = (r_state == StateMax) ? '0 : r_state + StateOne;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full   <= '0;
      r_wb     <= 1'b0;
      r_rb     <= 1'b0;
      r_wctr   <= '0;
      r_rctr   <= '0;
      r_shift  <= '0;
      r_state  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else begin
      if (w_wr) begin
        if (r_wctr == CtrMax) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= ~r_wb;
          r_wctr       <= '0;
        end else begin
          r_wctr <= r_wctr + CtrOne;
        end
      end
      // A bank being written is never full and a bank being read always is, so the set
      // above and the clear below never hit the same flag
      if (w_adv) begin
        r_tlast <= (r_rctr == CtrMax);
        r_tuser <= (r_rctr == '0) && (r_state == '0);
        if (r_rctr == CtrMax) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= ~r_rb;
          r_rctr       <= '0;
          r_shift      <= w_shift_nxt;
          r_state      <= w_state_nxt;
        end else begin
          r_rctr <= r_rctr + CtrOne;
        end
      end
      if (w_adv) begin
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/phasecomp_ctrl.md
# phasecomp_ctrl

Address and flow controller for the phase-compensation ping-pong RAM of the oversampled PFB. It sits between the polyphase FIR output and the FFT: it accepts one sample per handshake and writes each M-sample frame into one RAM half. It then reads the other half back with a circular offset that advances by the decimation factor D every frame, cycling through M/gcd(M,D) phase states. The block owns only addressing, bank bookkeeping and the AXI-Stream handshake. Sample data passes straight from the source to the RAM write port and from the RAM read port to the sink.

## Interface
- FFT_LEN, 64, M: samples per frame and size of each RAM half; power of two, ≥ 4
- DEC_FAC, 48, D: decimation factor; 1 ≤ D ≤ FFT_LEN
- DEPTH, 2*FFT_LEN, total RAM words; fixed at 2M
- AW, $clog2(DEPTH), RAM address width (derived)
- NUM_STATES, FFT_LEN/gcd(FFT_LEN,DEC_FAC), number of phase states (derived)
- SW, max(1,$clog2(NUM_STATES)), state index width (derived)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  upstream sample valid
- s_axis_tready  out  1  controller can accept a sample
- m_axis_tvalid  out  1  RAM read data on the output is valid
- m_axis_tready  in  1  downstream accepts the sample
- m_axis_tlast  out  1  last sample of an output frame
- m_axis_tuser  out  1  first sample of a frame in phase state 0
- ram_we  out  1  RAM write enable
- ram_waddr  out  AW  RAM write address
- ram_re  out  1  RAM read enable (synchronous read, 1-cycle latency, output held when ram_re=0)
- ram_raddr  out  AW  RAM read address
- state  out  SW  phase state of the frame currently being read

## Operation
- Bank flags full[1:0]; write bank pointer wb; read bank pointer rb; write counter wctr and read counter rctr, each 0..M-1.
- s_axis_tready = !full[wb].
- Write: ram_we = s_axis_tvalid && s_axis_tready; ram_waddr = {wb, wctr}.
  - On a write, wctr increments.
  - On the write with wctr = M-1: set full[wb], toggle wb, and wrap wctr to 0.
- Read advance: adv = full[rb] && (!m_axis_tvalid || m_axis_tready); ram_re = adv.
  - ram_raddr = {rb, (rctr + shift) mod M}.
  - On adv, rctr increments.
  - On adv with rctr = M-1: clear full[rb], toggle rb, wrap rctr, and update shift.
- Shift update: shift ← (shift + D ≥ M) ? shift + D − M : shift + D.
- State update: state ← (state = NUM_STATES−1) ? 0 : state+1.
  - shift therefore walks 0, D, 2D, … mod M and returns to 0 exactly when state wraps.
- Output valid register: on adv, m_axis_tvalid ← 1; else if m_axis_tready, m_axis_tvalid ← 0; else hold.
- Sideband registers: m_axis_tlast ← (rctr = M-1) and m_axis_tuser ← (rctr = 0 && state = 0), both loaded only on adv. They hold during stalls, aligned with the RAM data.
- Same-cycle set and clear of full[] always target opposite banks, so both updates apply.
- Reset (any time, including mid-frame): full = 0, wb = rb = 0, wctr = rctr = 0, shift = 0, state = 0. All outputs are 0 except s_axis_tready = 1. Partial frames are discarded.

## Timing
- Fill latency: with continuous input and m_axis_tready = 1, the first write is at cycle 0. full[0] is set at the end of cycle M−1. The first adv is at cycle M, and m_axis_tvalid is first high at cycle M+1.
- Steady state: 1 sample/clk in and out with no bubbles.
- Backpressure: m_axis_tvalid never drops without a handshake. While stalled, ram_re = 0, so the data holds.
- Input stall: once both banks are full, s_axis_tready is low until the reader releases a bank. The flag clears on the edge after the last read of that bank, so the upstream retry sees tready one cycle later.

## Test plan
- Reset, then a continuous counter source and tready = 1, with M=64, D=48. Required:
  - The first output is at cycle 65 and reads address 0.
  - Frame 1 starts at raddr 64+48 = 112; frame 2 starts at 32; frame 3 starts at 64+16 = 80; frame 4 starts at 0 with tuser = 1.
  - tlast is asserted every 64th output.
- Same stimulus, checking the output samples against a software model out[n] = frame_k[(n + 48k) mod 64], run for 8 frames. Required: zero mismatches.
- m_axis_tready is toggled in a 1-on/2-off pattern. Required:
  - tdata, tlast and tuser hold while stalled.
  - No sample is lost or duplicated.
  - s_axis_tready drops after the 128th unread sample.
- s_axis_tvalid is dropped at random. Required:
  - The output order is unchanged.
  - m_axis_tvalid gaps appear only when no bank is full.
- Assert rst low mid-frame (wctr = 30, rctr = 10). Required:
  - All outputs drop immediately.
  - After release, state = 0 and the next frame reads from address 0.
- D = M = 64 (NUM_STATES = 1). Required: shift stays 0, state stays 0, and tuser is set on every frame.
